// File: rtl/obi_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : obi_if
// Description : OBI A-channel and R-channel bundle between a master and a
//               subordinate.
// Revision    : 1.0 - initial release
// ============================================================================
interface obi_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      req;
  logic                      gnt;
  logic [ADDR_WIDTH-1:0]     addr;
  logic                      we;
  logic [DATA_WIDTH/8-1:0]   be;
  logic [DATA_WIDTH-1:0]     wdata;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      err;

  modport master (
    output req, addr, we, be, wdata, rready,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata, rready,
    output gnt, rvalid, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/obi_subordinate_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : obi_subordinate_mem
// Description : OBI subordinate backed by a word-addressed register memory.
//               Programmable grant wait, byte-enabled writes, in-order
//               responses through a small response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module obi_subordinate_mem #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    DEPTH          = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    GNT_DELAY      = 0,
  parameter int                    RSP_FIFO_DEPTH = 2
) (
  input wire   clk_i,
  input wire   reset_ni,
  obi_if.slave obi
);

  localparam int c_BE_W  = DATA_WIDTH / 8;
  localparam int c_OFF_W = $clog2(c_BE_W);
  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int c_PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;

  // Parameter legality is enforced while elaborating.
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
    $fatal(1, "obi_subordinate_mem: DATA_WIDTH must be 32 or 64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "obi_subordinate_mem: DEPTH must be a power of two >= 2");
  end
  if ((BASE_ADDR % c_BE_W) != 0) begin : g_bad_base
    $fatal(1, "obi_subordinate_mem: BASE_ADDR must be word aligned");
  end
  if (GNT_DELAY < 0 || GNT_DELAY > 15) begin : g_bad_gnt_delay
    $fatal(1, "obi_subordinate_mem: GNT_DELAY must be 0..15");
  end
  if (RSP_FIFO_DEPTH < 1) begin : g_bad_fifo_depth
    $fatal(1, "obi_subordinate_mem: RSP_FIFO_DEPTH must be >= 1");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [3:0]            r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_fifo_data [RSP_FIFO_DEPTH];
  logic                  r_fifo_err  [RSP_FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_fifo_cnt;
  logic [c_CNT_W-1:0]    w_cnt_nxt;
  logic                  r_rvalid;

  logic                  w_borrow;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [c_IDX_W-1:0]    w_idx;
  logic                  w_err;
  logic                  w_gnt;
  logic                  w_hs;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_rd_data;

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    if (p == c_PTR_W'(RSP_FIFO_DEPTH - 1)) return '0;
    return p + c_PTR_W'(1);
  endfunction

  // Address decode: a borrow out of the subtraction means addr < BASE_ADDR.
  assign {w_borrow, w_off} = {1'b0, obi.addr} - {1'b0, BASE_ADDR};
  assign w_word = w_off >> c_OFF_W;
  assign w_idx  = w_word[c_IDX_W-1:0];
  assign w_err  = w_borrow || (w_word >= ADDR_WIDTH'(DEPTH)) ||
                  (w_off[c_OFF_W-1:0] != '0);

  // Grant is held low throughout reset even when no wait is configured.
  assign w_gnt = reset_ni && obi.req && (r_wait_cnt == 4'(GNT_DELAY)) &&
                 (r_fifo_cnt < c_CNT_W'(RSP_FIFO_DEPTH));
  assign w_hs  = obi.req && w_gnt;
  assign w_pop = r_rvalid && obi.rready;

  assign w_rd_data = (w_err || obi.we) ? '0 : r_mem[w_idx];

  // Wait counter: counts ungranted request cycles, saturates at GNT_DELAY.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wait_cnt <= '0;
    end else if (w_hs || !obi.req) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != 4'(GNT_DELAY)) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // Memory: byte-enabled write on an error-free write handshake.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_hs && obi.we && !w_err) begin
      for (int b = 0; b < c_BE_W; b++) begin
        if (obi.be[b]) r_mem[w_idx][b*8 +: 8] <= obi.wdata[b*8 +: 8];
      end
    end
  end

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    w_cnt_nxt = r_fifo_cnt;
    if (w_hs && !w_pop) begin
      w_cnt_nxt = r_fifo_cnt + c_CNT_W'(1);
    end else if (!w_hs && w_pop) begin
      w_cnt_nxt = r_fifo_cnt - c_CNT_W'(1);
    end
  end

  // Response FIFO control; rvalid is registered from the next occupancy.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      if (w_hs)  r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_fifo_cnt <= w_cnt_nxt;
      r_rvalid   <= (w_cnt_nxt != '0);
    end
  end

  // Response FIFO storage; contents are only observed while rvalid is high.
  always_ff @(posedge clk_i) begin
    if (w_hs) begin
      r_fifo_data[r_wr_ptr] <= w_rd_data;
      r_fifo_err[r_wr_ptr]  <= w_err;
    end
  end

  assign obi.gnt    = w_gnt;
  assign obi.rvalid = r_rvalid;
  assign obi.rdata  = r_rvalid ? r_fifo_data[r_rd_ptr] : '0;
  assign obi.err    = r_rvalid && r_fifo_err[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_obi_subordinate_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_obi_subordinate_mem
// Description : Self-checking bench for obi_subordinate_mem. A queue/array
//               model tracks the main instance every cycle; a second instance
//               with grant wait states is checked with directed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_subordinate_mem;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int DEPTH  = 16;
  localparam int FIFO_D = 2;
  localparam longint BASE = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  obi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
  obi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

  obi_subordinate_mem #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .BASE_ADDR(32'h0),
    .GNT_DELAY(0), .RSP_FIFO_DEPTH(FIFO_D)
  ) u_dut (
    .clk_i(clk), .reset_ni(rst_n), .obi(bus)
  );

  obi_subordinate_mem #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .BASE_ADDR(32'h0),
    .GNT_DELAY(3), .RSP_FIFO_DEPTH(FIFO_D)
  ) u_dut3 (
    .clk_i(clk), .reset_ni(rst_n), .obi(bus3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the main instance ----------------
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        m_q[$];
  logic [31:0] m_mem [DEPTH];

  always @(negedge clk) begin
    bit     exp_gnt;
    bit     hs;
    bit     pop;
    rsp_t   r;
    longint off;
    if (!rst_n) begin
      m_q.delete();
      foreach (m_mem[i]) m_mem[i] = 32'h0;
      chk("rst_gnt",    bus.gnt,    0);
      chk("rst_rvalid", bus.rvalid, 0);
      chk("rst_rdata",  bus.rdata,  0);
      chk("rst_err",    bus.err,    0);
    end else begin
      exp_gnt = bus.req && (m_q.size() < FIFO_D);
      chk("m_gnt",    bus.gnt,    exp_gnt);
      chk("m_rvalid", bus.rvalid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("m_rdata", bus.rdata, m_q[0].rdata);
        chk("m_err",   bus.err,   m_q[0].err);
      end else begin
        chk("m_rdata_idle", bus.rdata, 0);
        chk("m_err_idle",   bus.err,   0);
      end
      // Effect of the coming rising edge.
      pop = (m_q.size() != 0) && bus.rready;
      hs  = bus.req && exp_gnt;
      r   = '0;
      if (hs) begin
        off     = longint'(bus.addr) - BASE;
        r.err   = (off < 0) || (off % 4 != 0) || (off / 4 >= DEPTH);
        r.rdata = (r.err || bus.we) ? 32'h0 : m_mem[off / 4];
        if (bus.we && !r.err) begin
          for (int b = 0; b < 4; b++)
            if (bus.be[b]) m_mem[off / 4][8*b +: 8] = bus.wdata[8*b +: 8];
        end
      end
      if (pop) void'(m_q.pop_front());
      if (hs)  m_q.push_back(r);
    end
  end

  // ---------------- stimulus helpers (called just after a rising edge) ----
  task automatic xfer(input logic [31:0] a, input logic we, input logic [3:0] be,
                      input logic [31:0] wd, output int waited);
    bus.req = 1'b1; bus.addr = a; bus.we = we; bus.be = be; bus.wdata = wd;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.gnt && waited < 50);
    if (!bus.gnt) chk("xfer_gnt_timeout", bus.gnt, 1);
    @(posedge clk); #1;
    bus.req = 1'b0; bus.we = 1'b0;
  endtask

  task automatic expect_rsp(input string nm, input logic [31:0] d, input logic e,
                            output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.rvalid && waited < 50);
    chk({nm, "_rvalid"}, bus.rvalid, 1);
    chk({nm, "_rdata"},  bus.rdata,  d);
    chk({nm, "_err"},    bus.err,    e);
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    bus.req = 0; bus.addr = 0; bus.we = 0; bus.be = 0; bus.wdata = 0; bus.rready = 1;
    bus3.req = 0; bus3.addr = 0; bus3.we = 0; bus3.be = 4'hF; bus3.wdata = 0; bus3.rready = 1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rvalid", bus.rvalid, 0);
    @(posedge clk); #1;

    // T1 write then read
    xfer(32'h8, 1, 4'hF, 32'hDEADBEEF, w);
    chk("t1_gnt_cycles", w, 1);
    expect_rsp("t1_wr", 32'h0, 0, w);
    chk("t1_rsp_latency", w, 1);
    xfer(32'h8, 0, 4'hF, 32'h0, w);
    expect_rsp("t1_rd", 32'hDEADBEEF, 0, w);

    // T2 byte enables: bytes 0 and 2 take the new data; be=0 writes nothing
    xfer(32'hC, 1, 4'hF, 32'h11223344, w);  expect_rsp("t2_pre", 0, 0, w);
    xfer(32'hC, 1, 4'b0101, 32'hAABBCCDD, w); expect_rsp("t2_wr", 0, 0, w);
    xfer(32'hC, 1, 4'b0000, 32'hFFFFFFFF, w); expect_rsp("t2_be0", 0, 0, w);
    xfer(32'hC, 0, 4'h0, 32'h0, w);          expect_rsp("t2_rd", 32'h11BB33DD, 0, w);

    // T3 errors and address boundaries
    xfer(32'h40, 0, 4'hF, 32'h0, w);         expect_rsp("t3_oor_rd", 0, 1, w);
    xfer(32'h41, 1, 4'hF, 32'hFFFFFFFF, w);  expect_rsp("t3_mis_wr", 0, 1, w);
    xfer(32'h0, 0, 4'hF, 32'h0, w);          expect_rsp("t3_rd0", 0, 0, w);
    xfer(32'h3C, 1, 4'hF, 32'h5A5A0F0F, w);  expect_rsp("t3_last_wr", 0, 0, w);
    xfer(32'h3C, 0, 4'hF, 32'h0, w);         expect_rsp("t3_last_rd", 32'h5A5A0F0F, 0, w);

    // Back-to-back write then read of the same word
    bus.req = 1; bus.addr = 32'h20; bus.we = 1; bus.be = 4'hF; bus.wdata = 32'hCAFEF00D;
    @(negedge clk);
    @(posedge clk); #1 bus.we = 0;
    @(negedge clk);
    chk("b2b_wr_rvalid", bus.rvalid, 1);
    chk("b2b_wr_rdata",  bus.rdata,  0);
    @(posedge clk); #1 bus.req = 0;
    @(negedge clk);
    chk("b2b_rd_rdata", bus.rdata, 32'hCAFEF00D);
    @(posedge clk); #1;

    // T4 backpressure
    xfer(32'h10, 1, 4'hF, 32'h10101010, w); expect_rsp("t4_p0", 0, 0, w);
    xfer(32'h14, 1, 4'hF, 32'h20202020, w); expect_rsp("t4_p1", 0, 0, w);
    xfer(32'h18, 1, 4'hF, 32'h30303030, w); expect_rsp("t4_p2", 0, 0, w);
    bus.rready = 0;
    bus.req = 1; bus.we = 0; bus.be = 4'hF; bus.addr = 32'h10;
    @(negedge clk); chk("t4_gnt_a", bus.gnt, 1);
    @(posedge clk); #1 bus.addr = 32'h14;
    @(negedge clk); chk("t4_gnt_b", bus.gnt, 1);
    chk("t4_head_a", bus.rdata, 32'h10101010);
    @(posedge clk); #1 bus.addr = 32'h18;
    @(negedge clk); chk("t4_gnt_c_full", bus.gnt, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("t4_gnt_c_full2", bus.gnt, 0);
    chk("t4_stall_rdata", bus.rdata, 32'h10101010);
    @(posedge clk); #1 bus.rready = 1;
    @(negedge clk); chk("t4_gnt_pop_cycle", bus.gnt, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("t4_gnt_c", bus.gnt, 1);
    chk("t4_head_b", bus.rdata, 32'h20202020);
    @(posedge clk); #1 bus.req = 0;
    @(negedge clk); chk("t4_head_c", bus.rdata, 32'h30303030);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;

    // T5 wait states on the GNT_DELAY=3 instance
    bus3.req = 1; bus3.addr = 32'h4; bus3.we = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("t5_gnt_c%0d", i), bus3.gnt, (i == 4));
    end
    @(posedge clk); #1 bus3.req = 0;
    @(negedge clk);
    chk("t5_rvalid", bus3.rvalid, 1);
    chk("t5_err",    bus3.err,    0);
    @(posedge clk); #1 bus3.req = 1;
    @(negedge clk); chk("t5_part_c1", bus3.gnt, 0);
    @(negedge clk); chk("t5_part_c2", bus3.gnt, 0);
    @(posedge clk); #1 bus3.req = 0;
    @(posedge clk); #1 bus3.req = 1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("t5_restart_c%0d", i), bus3.gnt, (i == 4));
    end
    @(posedge clk); #1 bus3.req = 0;

    // T6 reset with responses queued
    bus.rready = 0;
    xfer(32'h8, 0, 4'hF, 32'h0, w);
    xfer(32'hC, 0, 4'hF, 32'h0, w);
    @(negedge clk); chk("t6_queued_rvalid", bus.rvalid, 1);
    @(posedge clk); #2;
    rst_n = 0; bus.req = 1; bus.addr = 32'h8;
    #1;
    chk("t6_rst_rvalid", bus.rvalid, 0);
    chk("t6_rst_gnt",    bus.gnt,    0);
    chk("t6_rst_rdata",  bus.rdata,  0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1; bus.req = 0; bus.rready = 1;
    @(negedge clk); chk("t6_no_stale1", bus.rvalid, 0);
    @(negedge clk); chk("t6_no_stale2", bus.rvalid, 0);
    @(posedge clk); #1;
    xfer(32'h8, 0, 4'hF, 32'h0, w); expect_rsp("t6_rd8", 32'h0, 0, w);
    xfer(32'hC, 0, 4'hF, 32'h0, w); expect_rsp("t6_rdC", 32'h0, 0, w);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
